// File: rtl/sub_serial_pkg.sv
// Shared types and sizing helpers for the nibble-serial borrow-lookahead subtractor.
package sub_serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int NIB = 4;

  typedef struct packed {
    logic [31:0] nibbles;
    logic [31:0] idx_w;
  } sizes_t;

  // A one-nibble datapath still needs a 1-bit index so the counter has a legal width.
  function automatic sizes_t calc_sizes(input int width);
    sizes_t s;
    s.nibbles = width / NIB;
    s.idx_w   = (s.nibbles > 1) ? $clog2(s.nibbles) : 1;
    return s;
  endfunction

endpackage

// File: rtl/bla_sub_4bit.sv
// Combinational 4-bit borrow-lookahead subtract slice: d = a - b - bi, bo = final borrow.
module bla_sub_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_br;

  // Borrow is generated where a=0,b=1 and passed through where the bits are equal.
  assign w_g = ~a & b;
  assign w_p = ~(a ^ b);

  assign w_br[0] = bi;
  assign w_br[1] = w_g[0] | (w_p[0] & bi);
  assign w_br[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & bi);
  assign w_br[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & bi);
  assign w_br[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & bi);

  assign d  = a ^ b ^ w_br[3:0];
  assign bo = w_br[4];

endmodule

// File: rtl/sub_serial_bla.sv
// Nibble-serial WIDTH-bit subtractor (a - b - bin), LSB nibble first through one lookahead slice,
// with valid/ready handshakes on both sides and a single operation in flight.
module sub_serial_bla
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam sizes_t SZ   = calc_sizes(WIDTH);
  localparam int     NNIB = int'(SZ.nibbles);
  localparam int     IW   = int'(SZ.idx_w);
  localparam logic [IW-1:0] LAST = IW'(NNIB - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_borrow;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_out_valid;

  logic [NIB-1:0] w_a_nibs [NNIB];
  logic [NIB-1:0] w_b_nibs [NNIB];
  logic [NIB-1:0] w_a_k;
  logic [NIB-1:0] w_b_k;
  logic [NIB-1:0] w_d;
  logic           w_bo;

  for (genvar k = 0; k < NNIB; k++) begin : g_nibs
    assign w_a_nibs[k] = r_a[k*NIB +: NIB];
    assign w_b_nibs[k] = r_b[k*NIB +: NIB];
  end

  assign w_a_k = w_a_nibs[r_idx];
  assign w_b_k = w_b_nibs[r_idx];

  bla_sub_4bit u_slice (
    .a  (w_a_k),
    .b  (w_b_k),
    .bi (r_borrow),
    .d  (w_d),
    .bo (w_bo)
  );

  // Gated by rst_n so the producer sees no acceptance while reset is held.
  assign in_ready  = (r_state == IDLE) && rst_n;
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign overflow  = r_ovf;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: operand and borrow registers are left unreset; they are always loaded before use.
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_idx    <= '0;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          for (int k = 0; k < NNIB; k++) begin
            if (r_idx == IW'(k)) r_diff[k*NIB +: NIB] <= w_d;
          end
          r_borrow <= w_bo;
          r_idx    <= r_idx + IW'(1);
          if (r_idx == LAST) begin
            // The final nibble's top bit is the result MSB; r_diff is not written yet.
            r_bout      <= w_bo;
            r_ovf       <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_d[NIB-1] ^ r_a[WIDTH-1]);
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
